// File: rtl/updown_mod_counter.sv
// Synchronous up/down counter with programmable modulus, clamped variable step,
// parallel load, and wrap or saturate behaviour at the 0/MOD_MAX boundaries.
module updown_mod_counter #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned MOD_MAX  = (1 << WIDTH) - 1,
  parameter bit          SATURATE = 1'b0,
  parameter int unsigned RST_VAL  = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic [WIDTH-1:0] step,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             at_max,
  output logic             at_min
);

  localparam int unsigned EW = WIDTH + 1;
  localparam logic [EW-1:0]    MAX_EXT = EW'(MOD_MAX);
  localparam logic [EW-1:0]    MODULUS = MAX_EXT + EW'(1);
  localparam logic [WIDTH-1:0] MAX_CNT = WIDTH'(MOD_MAX);
  localparam logic [WIDTH-1:0] RST_CNT = WIDTH'(RST_VAL);

  logic [WIDTH-1:0] count_q, count_d;
  logic             tc_q, tc_d;

  logic [EW-1:0] cnt_ext;
  logic [EW-1:0] step_ext;
  logic [EW-1:0] step_eff;
  logic [EW-1:0] load_ext;
  logic [EW-1:0] load_eff;
  logic [EW-1:0] sum_up;
  logic [EW-1:0] wrap_up;
  logic [EW-1:0] diff_dn;
  logic [EW-1:0] wrap_dn;
  logic          over_up;
  logic          under_dn;
  logic [EW-1:0] next_ext;

  // One extra bit of headroom keeps count+step and count+M-step exact.
  always_comb begin
    cnt_ext  = {1'b0, count_q};
    step_ext = {1'b0, step};
    load_ext = {1'b0, load_val};
    step_eff = (step_ext > MAX_EXT) ? MAX_EXT : step_ext;
    load_eff = (load_ext > MAX_EXT) ? MAX_EXT : load_ext;
    sum_up   = cnt_ext + step_eff;
    wrap_up  = sum_up - MODULUS;
    diff_dn  = cnt_ext - step_eff;
    wrap_dn  = cnt_ext + MODULUS - step_eff;
    over_up  = (sum_up > MAX_EXT);
    under_dn = (step_eff > cnt_ext);
  end

  always_comb begin
    next_ext = cnt_ext;
    tc_d     = 1'b0;
    if (load) begin
      next_ext = load_eff;
    end else if (en && (step_eff != '0)) begin
      if (up) begin
        if (over_up) begin
          next_ext = SATURATE ? MAX_EXT : wrap_up;
          tc_d     = 1'b1;
        end else begin
          next_ext = sum_up;
        end
      end else begin
        if (under_dn) begin
          next_ext = SATURATE ? '0 : wrap_dn;
          tc_d     = 1'b1;
        end else begin
          next_ext = diff_dn;
        end
      end
    end
    count_d = next_ext[WIDTH-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= RST_CNT;
      tc_q    <= 1'b0;
    end else begin
      count_q <= count_d;
      tc_q    <= tc_d;
    end
  end

  assign count  = count_q;
  assign tc     = tc_q;
  assign at_max = (count_q == MAX_CNT);
  assign at_min = (count_q == '0);

endmodule

// File: tb/tb_updown_mod_counter.sv
// Drives three counter configurations (4-bit wrap, 4-bit saturate, 8-bit wrap)
// from one stimulus stream and checks them against a behavioural scoreboard.
module tb_updown_mod_counter;

  logic       clk = 1'b0;
  logic       rst, en, up, load;
  logic [7:0] step, load_val;

  logic [3:0] cnt_w, cnt_s;
  logic [7:0] cnt_8;
  logic       tc_w, tc_s, tc_8;
  logic       max_w, max_s, max_8;
  logic       min_w, min_s, min_8;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  updown_mod_counter #(.WIDTH(4), .MOD_MAX(9), .SATURATE(1'b0), .RST_VAL(0)) dut_wrap (
    .clk(clk), .rst(rst), .en(en), .up(up), .step(step[3:0]), .load(load),
    .load_val(load_val[3:0]), .count(cnt_w), .tc(tc_w), .at_max(max_w), .at_min(min_w)
  );

  updown_mod_counter #(.WIDTH(4), .MOD_MAX(9), .SATURATE(1'b1), .RST_VAL(3)) dut_sat (
    .clk(clk), .rst(rst), .en(en), .up(up), .step(step[3:0]), .load(load),
    .load_val(load_val[3:0]), .count(cnt_s), .tc(tc_s), .at_max(max_s), .at_min(min_s)
  );

  updown_mod_counter #(.WIDTH(8)) dut_w8 (
    .clk(clk), .rst(rst), .en(en), .up(up), .step(step), .load(load),
    .load_val(load_val), .count(cnt_8), .tc(tc_8), .at_max(max_8), .at_min(min_8)
  );

  typedef struct {
    bit         rst;
    bit         load;
    logic [7:0] load_val;
    bit         en;
    bit         up;
    logic [7:0] step;
    int         exp_cnt;
    int         exp_tc;
  } stim_t;

  typedef struct packed {
    logic [2:0][7:0] cnt;
    logic [2:0]      tc;
  } exp_t;

  exp_t  sb_q[$];
  stim_t vec[$];

  int cfg_max[3]  = '{9, 9, 255};
  int cfg_mask[3] = '{15, 15, 255};
  int cfg_sat[3]  = '{0, 1, 0};
  int cfg_rst[3]  = '{0, 3, 0};
  int model_cnt[3] = '{0, 0, 0};

  function automatic stim_t mk(bit r, bit ld, int lv, bit e, bit u, int st, int ec, int et);
    stim_t s;
    s.rst = r; s.load = ld; s.load_val = 8'(lv); s.en = e; s.up = u; s.step = 8'(st);
    s.exp_cnt = ec; s.exp_tc = et;
    return s;
  endfunction

  function automatic void model_next(input int idx, input int cur, input stim_t s,
                                     output int nxt, output bit ntc);
    int mx, lv, st;
    mx  = cfg_max[idx];
    nxt = cur;
    ntc = 1'b0;
    lv  = int'(s.load_val) & cfg_mask[idx];
    st  = int'(s.step) & cfg_mask[idx];
    if (st > mx) st = mx;
    if (s.rst) begin
      nxt = cfg_rst[idx];
    end else if (s.load) begin
      nxt = (lv > mx) ? mx : lv;
    end else if (s.en && st != 0) begin
      if (s.up) begin
        if (cur + st > mx) begin
          nxt = (cfg_sat[idx] != 0) ? mx : cur + st - (mx + 1);
          ntc = 1'b1;
        end else begin
          nxt = cur + st;
        end
      end else begin
        if (st > cur) begin
          nxt = (cfg_sat[idx] != 0) ? 0 : cur + (mx + 1) - st;
          ntc = 1'b1;
        end else begin
          nxt = cur - st;
        end
      end
    end
  endfunction

  task automatic checkValue(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input stim_t s);
    exp_t e;
    int   n;
    bit   t;
    @(negedge clk);
    rst = s.rst; load = s.load; load_val = s.load_val;
    en = s.en; up = s.up; step = s.step;
    for (int i = 0; i < 3; i++) begin
      model_next(i, model_cnt[i], s, n, t);
      model_cnt[i] = n;
      e.cnt[i] = 8'(n);
      e.tc[i]  = t;
    end
    sb_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag);
    exp_t e;
    int   act_cnt[3];
    bit   act_tc[3], act_max[3], act_min[3];
    if (sb_q.size() == 0) begin
      checkValue({tag, "_sb_empty"}, 0, 1);
      return;
    end
    e = sb_q.pop_front();
    act_cnt = '{int'(cnt_w), int'(cnt_s), int'(cnt_8)};
    act_tc  = '{tc_w, tc_s, tc_8};
    act_max = '{max_w, max_s, max_8};
    act_min = '{min_w, min_s, min_8};
    for (int i = 0; i < 3; i++) begin
      checkValue($sformatf("%s_d%0d_count", tag, i), act_cnt[i], int'(e.cnt[i]));
      checkValue($sformatf("%s_d%0d_tc", tag, i), int'(act_tc[i]), int'(e.tc[i]));
      checkValue($sformatf("%s_d%0d_at_max", tag, i), int'(act_max[i]),
                 int'(e.cnt[i]) == cfg_max[i] ? 1 : 0);
      checkValue($sformatf("%s_d%0d_at_min", tag, i), int'(act_min[i]),
                 int'(e.cnt[i]) == 0 ? 1 : 0);
    end
  endtask

  task automatic step_once(input string tag, input bit r, input bit ld, input int lv,
                           input bit e, input bit u, input int st);
    applyStimulus(mk(r, ld, lv, e, u, st, -1, -1));
    checkOutput(tag);
  endtask

  initial begin
    rst = 1'b1; load = 1'b0; en = 1'b0; up = 1'b1; step = '0; load_val = '0;

    // Table: inputs plus hand-derived expectations for the 4-bit MOD_MAX=9 wrap counter.
    vec.push_back(mk(1, 0, 0, 0, 1, 0, 0, 0));
    for (int i = 1; i <= 10; i++) vec.push_back(mk(0, 0, 0, 1, 1, 1, i % 10, (i == 10) ? 1 : 0));
    vec.push_back(mk(0, 0, 0, 1, 0, 3, 7, 1));
    vec.push_back(mk(0, 0, 0, 1, 0, 3, 4, 0));
    vec.push_back(mk(0, 0, 0, 1, 0, 4, 0, 0));
    vec.push_back(mk(0, 1, 12, 1, 1, 1, 9, 0));
    vec.push_back(mk(0, 1, 5, 1, 1, 1, 5, 0));
    vec.push_back(mk(0, 0, 0, 1, 1, 2, 7, 0));
    vec.push_back(mk(1, 1, 6, 1, 1, 1, 0, 0));
    vec.push_back(mk(0, 0, 0, 1, 1, 1, 1, 0));
    vec.push_back(mk(0, 0, 0, 0, 1, 7, 1, 0));
    vec.push_back(mk(0, 0, 0, 1, 1, 0, 1, 0));
    vec.push_back(mk(0, 0, 0, 1, 1, 15, 0, 1));
    vec.push_back(mk(0, 0, 0, 1, 0, 1, 9, 1));

    foreach (vec[k]) begin
      applyStimulus(vec[k]);
      checkOutput($sformatf("vec%0d", k));
      checkValue($sformatf("vec%0d_tbl_count", k), int'(cnt_w), vec[k].exp_cnt);
      checkValue($sformatf("vec%0d_tbl_tc", k), int'(tc_w), vec[k].exp_tc);
    end

    // Saturating counter blocked at MOD_MAX keeps pulsing tc, then clamps at zero.
    step_once("sat_load", 0, 1, 8, 0, 1, 0);
    for (int i = 0; i < 4; i++) begin
      step_once("sat_up", 0, 0, 0, 1, 1, 5);
      checkValue($sformatf("sat_block%0d_count", i), int'(cnt_s), 9);
      checkValue($sformatf("sat_block%0d_tc", i), int'(tc_s), 1);
    end
    step_once("sat_land0", 0, 0, 0, 1, 0, 15);
    checkValue("sat_land0_count", int'(cnt_s), 0);
    checkValue("sat_land0_tc", int'(tc_s), 0);
    step_once("sat_under", 0, 0, 0, 1, 0, 15);
    checkValue("sat_under_count", int'(cnt_s), 0);
    checkValue("sat_under_tc", int'(tc_s), 1);

    // 8-bit full-range wrap and enable-low hold.
    step_once("w8_load", 0, 1, 250, 1, 0, 3);
    checkValue("w8_load_count", int'(cnt_8), 250);
    step_once("w8_wrap", 0, 0, 0, 1, 1, 10);
    checkValue("w8_wrap_count", int'(cnt_8), 4);
    checkValue("w8_wrap_tc", int'(tc_8), 1);
    step_once("w8_hold", 0, 0, 0, 0, 1, 77);
    checkValue("w8_hold_count", int'(cnt_8), 4);
    checkValue("w8_hold_tc", int'(tc_8), 0);

    // Reset mid-count drops pending events; sat counter returns to its RST_VAL.
    step_once("rst_mid", 1, 1, 2, 1, 1, 1);
    checkValue("rst_mid_sat_count", int'(cnt_s), 3);
    step_once("resume", 0, 0, 0, 1, 0, 5);

    // Randomised sweep against the scoreboard.
    for (int i = 0; i < 200; i++) begin
      step_once("rand", ($urandom_range(0, 31) == 0), ($urandom_range(0, 9) == 0),
                int'($urandom_range(0, 255)), ($urandom_range(0, 3) != 0),
                bit'($urandom_range(0, 1)), int'($urandom_range(0, 255)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
